// File: rtl/cassette_recorder_if.sv
// cassette_recorder_if: byte write port from the tape decoder into the tape buffer RAM.
interface cassette_recorder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_data;
    logic              bram_wr;

    modport master (output bram_addr, output bram_data, output bram_wr);
    modport slave  (input  bram_addr, input  bram_data, input  bram_wr);
endinterface

// File: rtl/cassette_recorder.sv
// cassette_recorder: decodes a period-modulated tape stream into framed bytes written to a buffer RAM.
// Parity checking is optional and enabled by defining CASREC_PARITY_CHECK_EN.
module cassette_recorder #(
    parameter int ADDR_W      = 16,
    parameter int PER_MIN     = 5000,
    parameter int PER_SPLIT   = 31250,
    parameter int PER_TIMEOUT = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                rewind,
    input  logic                tape_in,
    cassette_recorder_if.master bram,
    output logic [ADDR_W:0]     tape_len,
    output logic                full,
    output logic                frame_err,
    output logic                parity_err,
    output logic                active
);
    localparam int                CNT_W   = $clog2(PER_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0]  SPLIT_C = CNT_W'(PER_SPLIT);
    localparam logic [CNT_W-1:0]  TO_C    = CNT_W'(PER_TIMEOUT);
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [2:0]        sync_r;
    logic              rise_s;
    logic              timeout_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              bit_valid_r;
    logic              bit_val_r;
    state_t            state_r;
    logic [2:0]        idx_r;
    logic [7:0]        shift_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] bram_addr_r;
    logic [7:0]        bram_data_r;
    logic              bram_wr_r;
    logic [ADDR_W:0]   tape_len_r;
    logic              full_r;
    logic              frame_err_r;
    logic              parity_err_r;
    logic              active_r;

`ifdef CASREC_PARITY_CHECK_EN
    function automatic logic parity_even_f(input logic [7:0] d);
        return ~(^d);
    endfunction
`endif

    assign rise_s    = sync_r[1] & ~sync_r[2];
    assign timeout_s = (cnt_r == TO_C);

    // Synchronize tape_in, measure edge-to-edge periods and emit one decoded bit per qualifying edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r      <= 3'b000;
            cnt_r       <= '0;
            bit_valid_r <= 1'b0;
            bit_val_r   <= 1'b0;
        end else begin
            sync_r      <= {sync_r[1:0], tape_in};
            bit_valid_r <= 1'b0;
            if (!en) begin
                cnt_r <= '0;
            end else if (rise_s && (cnt_r >= MIN_C)) begin
                // A saturated count marks the end of a gap, not a real bit period.
                cnt_r       <= '0;
                bit_valid_r <= (cnt_r != TO_C);
                bit_val_r   <= (cnt_r < SPLIT_C);
            end else if (cnt_r != TO_C) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Frame FSM, buffer pointer and registered write port / status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= HUNT;
            idx_r        <= 3'd0;
            shift_r      <= 8'h00;
            ptr_r        <= '0;
            bram_addr_r  <= '0;
            bram_data_r  <= 8'h00;
            bram_wr_r    <= 1'b0;
            tape_len_r   <= '0;
            full_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            active_r     <= 1'b0;
        end else if (rewind) begin
            state_r      <= HUNT;
            ptr_r        <= '0;
            bram_wr_r    <= 1'b0;
            tape_len_r   <= '0;
            full_r       <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            active_r     <= 1'b0;
        end else begin
            bram_wr_r <= 1'b0;
            if (bram_wr_r) begin
                tape_len_r <= tape_len_r + (ADDR_W + 1)'(1);
                if (ptr_r == PTR_MAX) begin
                    full_r <= 1'b1;
                end else begin
                    ptr_r <= ptr_r + ADDR_W'(1);
                end
            end

            if (!en || (timeout_s && (state_r != HUNT))) begin
                state_r  <= HUNT;
                active_r <= 1'b0;
            end else if (bit_valid_r) begin
                case (state_r)
                    HUNT: begin
                        if (!bit_val_r) begin
                            state_r  <= DATA;
                            idx_r    <= 3'd0;
                            active_r <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_r <= {bit_val_r, shift_r[7:1]};
                        idx_r   <= idx_r + 3'd1;
                        if (idx_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef CASREC_PARITY_CHECK_EN
                        if (bit_val_r != parity_even_f(shift_r)) begin
                            parity_err_r <= 1'b1;
                        end
`endif
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r  <= HUNT;
                        active_r <= 1'b0;
                        if (!bit_val_r) begin
                            frame_err_r <= 1'b1;
                        end else if (!full_r) begin
                            bram_wr_r   <= 1'b1;
                            bram_addr_r <= ptr_r;
                            bram_data_r <= shift_r;
                        end
                    end
                    default: begin
                        state_r  <= HUNT;
                        active_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bram.bram_addr = bram_addr_r;
    assign bram.bram_data = bram_data_r;
    assign bram.bram_wr   = bram_wr_r;
    assign tape_len       = tape_len_r;
    assign full           = full_r;
    assign frame_err      = frame_err_r;
    assign parity_err     = parity_err_r;
    assign active         = active_r;
endmodule

// File: tb/tb_cassette_recorder.sv
// tb_cassette_recorder: scoreboard bench for cassette_recorder with time-scaled bit periods.
module tb_cassette_recorder;
    localparam int PMIN   = 25;
    localparam int PSPLIT = 156;
    localparam int PTO    = 500;
    localparam int ONE_P  = 104;
    localparam int ZERO_P = 208;
    localparam int GAP    = 600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en_a, en_b, rewind, tape;
    logic [16:0] len_a;
    logic [2:0]  len_b;
    logic full_a, ferr_a, perr_a, act_a;
    logic full_b, ferr_b, perr_b, act_b;

    cassette_recorder_if #(.ADDR_W(16)) bram_a ();
    cassette_recorder_if #(.ADDR_W(2))  bram_b ();

    cassette_recorder #(.ADDR_W(16), .PER_MIN(PMIN), .PER_SPLIT(PSPLIT), .PER_TIMEOUT(PTO)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .rewind(rewind), .tape_in(tape), .bram(bram_a),
        .tape_len(len_a), .full(full_a), .frame_err(ferr_a), .parity_err(perr_a), .active(act_a));

    cassette_recorder #(.ADDR_W(2), .PER_MIN(PMIN), .PER_SPLIT(PSPLIT), .PER_TIMEOUT(PTO)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .rewind(rewind), .tape_in(tape), .bram(bram_b),
        .tape_len(len_b), .full(full_b), .frame_err(ferr_b), .parity_err(perr_b), .active(act_b));

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    wr_t ea, eb;
    int n_assert = 0;
    int n_fail   = 0;
    logic exp_perr;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bram_a.bram_wr === 1'b1) begin
            n_assert++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL wr_a_unexpected: got addr %0h data %0h, expected no write", bram_a.bram_addr, bram_a.bram_data);
            end else begin
                ea = q_a.pop_front();
                if (bram_a.bram_addr !== ea.addr || bram_a.bram_data !== ea.data) begin
                    n_fail++;
                    $display("FAIL wr_a: got addr %0h data %0h, expected addr %0h data %0h", bram_a.bram_addr, bram_a.bram_data, ea.addr, ea.data);
                end
            end
        end
        if (bram_b.bram_wr === 1'b1) begin
            n_assert++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL wr_b_unexpected: got addr %0h data %0h, expected no write", bram_b.bram_addr, bram_b.bram_data);
            end else begin
                eb = q_b.pop_front();
                if (bram_b.bram_addr !== eb.addr[1:0] || bram_b.bram_data !== eb.data) begin
                    n_fail++;
                    $display("FAIL wr_b: got addr %0h data %0h, expected addr %0h data %0h", bram_b.bram_addr, bram_b.bram_data, eb.addr[1:0], eb.data);
                end
            end
        end
    end

    function automatic logic par_of(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic expect_a(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        q_a.push_back(w);
    endtask

    task automatic expect_b(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        q_b.push_back(w);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge at the start, so the period of this bit is closed by the next edge.
    task automatic edge_bit(input int p, input bit g);
        tape = 1'b1;
        wait_cyc(8);
        if (g) begin
            tape = 1'b0;
            wait_cyc(4);
            tape = 1'b1;
            wait_cyc(4);
            tape = 1'b0;
            wait_cyc(p - 16);
        end else begin
            tape = 1'b0;
            wait_cyc(p - 8);
        end
    endtask

    task automatic close_gap(input int n);
        tape = 1'b1;
        wait_cyc(8);
        tape = 1'b0;
        wait_cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stp, input int leader, input bit g);
        for (int i = 0; i < leader; i++) edge_bit(ONE_P, 1'b0);
        edge_bit(ZERO_P, 1'b0);
        for (int i = 0; i < 8; i++) edge_bit(d[i] ? ONE_P : ZERO_P, g);
        edge_bit(par ? ONE_P : ZERO_P, 1'b0);
        edge_bit(stp ? ONE_P : ZERO_P, 1'b0);
        close_gap(GAP);
    endtask

    task automatic do_rewind();
        rewind = 1'b1;
        wait_cyc(1);
        rewind = 1'b0;
        wait_cyc(1);
    endtask

    task automatic test_reset();
        wait_cyc(3);
        n_assert++; if (bram_a.bram_addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", bram_a.bram_addr); end
        n_assert++; if (bram_a.bram_data !== 8'h0) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", bram_a.bram_data); end
        n_assert++; if (bram_a.bram_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %0b expected 0", bram_a.bram_wr); end
        n_assert++; if (len_a !== 17'd0) begin n_fail++; $display("FAIL rst_len: got %0d expected 0", len_a); end
        n_assert++; if ({full_a, ferr_a, perr_a, act_a} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {full_a, ferr_a, perr_a, act_a}); end
        n_assert++; if ({full_b, ferr_b, perr_b, act_b, len_b} !== 7'b0) begin n_fail++; $display("FAIL rst_b: got %b expected 0", {full_b, ferr_b, perr_b, act_b, len_b}); end
        reset = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_single_frame();
        en_a = 1'b1;
        wait_cyc(GAP);
        expect_a(16'd0, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, 20, 1'b0);
        n_assert++; if (q_a.size() != 0) begin n_fail++; $display("FAIL single_pending: got %0d writes missing, expected 0", q_a.size()); end
        n_assert++; if (len_a !== 17'd1) begin n_fail++; $display("FAIL single_len: got %0d expected 1", len_a); end
        n_assert++; if ({ferr_a, perr_a, act_a} !== 3'b000) begin n_fail++; $display("FAIL single_flags: got %b expected 000", {ferr_a, perr_a, act_a}); end
    endtask

    task automatic test_back_to_back();
        do_rewind();
        n_assert++; if (len_a !== 17'd0) begin n_fail++; $display("FAIL b2b_rewind_len: got %0d expected 0", len_a); end
        expect_a(16'd0, 8'h01);
        expect_a(16'd1, 8'hFF);
        send_frame(8'h01, par_of(8'h01), 1'b1, 3, 1'b0);
        send_frame(8'hFF, par_of(8'hFF), 1'b1, 3, 1'b0);
        n_assert++; if (q_a.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d writes missing, expected 0", q_a.size()); end
        n_assert++; if (len_a !== 17'd2) begin n_fail++; $display("FAIL b2b_len: got %0d expected 2", len_a); end
        n_assert++; if ({ferr_a, perr_a} !== 2'b00) begin n_fail++; $display("FAIL b2b_flags: got %b expected 00", {ferr_a, perr_a}); end
    endtask

    task automatic test_parity();
`ifdef CASREC_PARITY_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        expect_a(16'd2, 8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
        n_assert++; if (q_a.size() != 0) begin n_fail++; $display("FAIL parity_pending: got %0d writes missing, expected 0", q_a.size()); end
        n_assert++; if (perr_a !== exp_perr) begin n_fail++; $display("FAIL parity_err: got %0b expected %0b", perr_a, exp_perr); end
        n_assert++; if (len_a !== 17'd3) begin n_fail++; $display("FAIL parity_len: got %0d expected 3", len_a); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h33, par_of(8'h33), 1'b0, 3, 1'b0);
        n_assert++; if (ferr_a !== 1'b1) begin n_fail++; $display("FAIL frame_err: got %0b expected 1", ferr_a); end
        n_assert++; if (len_a !== 17'd3) begin n_fail++; $display("FAIL frame_err_len: got %0d expected 3", len_a); end
    endtask

    task automatic test_timeout();
        do_rewind();
        for (int i = 0; i < 3; i++) edge_bit(ONE_P, 1'b0);
        edge_bit(ZERO_P, 1'b0);
        edge_bit(ONE_P, 1'b0);
        edge_bit(ZERO_P, 1'b0);
        edge_bit(ONE_P, 1'b0);
        edge_bit(ONE_P, 1'b0);
        close_gap(40);
        n_assert++; if (act_a !== 1'b1) begin n_fail++; $display("FAIL timeout_active_mid: got %0b expected 1", act_a); end
        wait_cyc(750);
        n_assert++; if (act_a !== 1'b0) begin n_fail++; $display("FAIL timeout_active: got %0b expected 0", act_a); end
        n_assert++; if ({ferr_a, perr_a} !== 2'b00) begin n_fail++; $display("FAIL timeout_flags: got %b expected 00", {ferr_a, perr_a}); end
        n_assert++; if (len_a !== 17'd0) begin n_fail++; $display("FAIL timeout_len: got %0d expected 0", len_a); end
    endtask

    task automatic test_glitch();
        expect_a(16'd0, 8'hC3);
        send_frame(8'hC3, par_of(8'hC3), 1'b1, 3, 1'b1);
        n_assert++; if (q_a.size() != 0) begin n_fail++; $display("FAIL glitch_pending: got %0d writes missing, expected 0", q_a.size()); end
        n_assert++; if (len_a !== 17'd1) begin n_fail++; $display("FAIL glitch_len: got %0d expected 1", len_a); end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 3; i++) edge_bit(ONE_P, 1'b0);
        edge_bit(ZERO_P, 1'b0);
        for (int i = 0; i < 3; i++) edge_bit(ONE_P, 1'b0);
        en_a = 1'b0;
        wait_cyc(2);
        n_assert++; if (act_a !== 1'b0) begin n_fail++; $display("FAIL pause_active: got %0b expected 0", act_a); end
        for (int i = 0; i < 7; i++) edge_bit(ONE_P, 1'b0);
        close_gap(GAP);
        n_assert++; if (len_a !== 17'd1) begin n_fail++; $display("FAIL pause_len: got %0d expected 1", len_a); end
        en_a = 1'b1;
        wait_cyc(GAP);
        expect_a(16'd1, 8'h96);
        send_frame(8'h96, par_of(8'h96), 1'b1, 3, 1'b0);
        n_assert++; if (q_a.size() != 0) begin n_fail++; $display("FAIL resume_pending: got %0d writes missing, expected 0", q_a.size()); end
        n_assert++; if (len_a !== 17'd2) begin n_fail++; $display("FAIL resume_len: got %0d expected 2", len_a); end
    endtask

    task automatic test_full();
        logic [7:0] d;
        en_a = 1'b0;
        en_b = 1'b1;
        wait_cyc(GAP);
        for (int i = 0; i < 4; i++) begin
            d = 8'h10 + 8'(i);
            expect_b(16'(i), d);
            send_frame(d, par_of(d), 1'b1, 3, 1'b0);
        end
        n_assert++; if (full_b !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b expected 1", full_b); end
        d = 8'h14;
        send_frame(d, par_of(d), 1'b1, 3, 1'b0);
        n_assert++; if (q_b.size() != 0) begin n_fail++; $display("FAIL full_pending: got %0d writes missing, expected 0", q_b.size()); end
        n_assert++; if (len_b !== 3'd4) begin n_fail++; $display("FAIL full_len: got %0d expected 4", len_b); end
        do_rewind();
        n_assert++; if (len_b !== 3'd0) begin n_fail++; $display("FAIL rewind_len: got %0d expected 0", len_b); end
        n_assert++; if (full_b !== 1'b0) begin n_fail++; $display("FAIL rewind_full: got %0b expected 0", full_b); end
    endtask

    initial begin
        reset  = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        rewind = 1'b0;
        tape   = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_pause();
        test_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cassette_recorder.md
CASSETTE_RECORDER -- requirements
Module: cassette_recorder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: tape buffer address width.
REQ-002 SHALL have parameter PER_MIN, default 5000: shortest period accepted, in clk cycles; anything shorter is a glitch.
REQ-003 SHALL have parameter PER_SPLIT, default 31250: periods below this decode as bit 1, periods at or above it decode as bit 0.
REQ-004 SHALL have parameter PER_TIMEOUT, default 100000: gap length, in cycles, that aborts the current frame.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (CLK_50M domain).
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: cassette relay (motor) enable.
REQ-008 SHALL have port rewind, input, 1 bit: clears the buffer pointer.
REQ-009 SHALL have port tape_in, input, 1 bit: machine tape output, asynchronous.
REQ-010 SHALL have port bram_addr, output, ADDR_W bits: write address.
REQ-011 SHALL have port bram_data, output, 8 bits: write data.
REQ-012 SHALL have port bram_wr, output, 1 bit: one-cycle write strobe.
REQ-013 SHALL have port tape_len, output, ADDR_W+1 bits: number of bytes stored.
REQ-014 SHALL have port full, output, 1 bit: buffer exhausted.
REQ-015 SHALL have port frame_err, output, 1 bit: sticky stop-bit error.
REQ-016 SHALL have port parity_err, output, 1 bit: sticky parity error.
REQ-017 SHALL have port active, output, 1 bit: high while a frame is in progress.

Function
REQ-018 SHALL pass tape_in through a 2-FF synchronizer; a bit period is measured from one synchronized rising edge to the next.
REQ-019 SHALL keep a period counter that increments every cycle, saturates at PER_TIMEOUT, and clears on each rising edge.
REQ-020 SHALL ignore a rising edge whose period is below PER_MIN: counter not cleared, no bit emitted.
REQ-021 SHALL emit a bit on the cycle after the qualifying edge is detected.
REQ-022 SHALL implement FSM states HUNT, DATA, PARITY, STOP.
- HUNT: 1-bits are discarded; a 0-bit (start bit) moves to DATA with the bit index cleared.
- DATA: 8 bits are shifted in LSB-first, then the FSM moves to PARITY.
- PARITY: one bit is consumed, then the FSM moves to STOP.
- STOP: a 1-bit commits the byte and returns to HUNT; a 0-bit sets frame_err, drops the byte and returns to HUNT.
REQ-023 SHALL assert active in DATA, PARITY and STOP.
REQ-024 SHALL, on commit, pulse bram_wr for exactly one cycle, on the cycle after the stop bit, with bram_addr equal to the current pointer and bram_data equal to the byte; the pointer and tape_len increment on the following cycle.
REQ-025 SHALL, when the counter reaches PER_TIMEOUT outside HUNT, discard the partial byte and return to HUNT without raising any error flag.
REQ-026 SHALL, when the pointer is at 2^ADDR_W-1 after a write, set full; while full, further commits are dropped with no bram_wr and the pointer is held.
REQ-027 SHALL, while en is low, hold the FSM in HUNT, hold the counter at 0, ignore edges, and retain the pointer and tape_len (pause/resume).
REQ-028 SHALL, on rewind, synchronously clear the pointer, tape_len, full, frame_err and parity_err, and force HUNT.
REQ-029 SHALL give rewind priority over a commit in the same cycle: no bram_wr is issued.

Reset
REQ-030 SHALL, on reset assertion, asynchronously set bram_addr=0, bram_data=0, bram_wr=0, tape_len=0, full=0, frame_err=0, parity_err=0, active=0, FSM=HUNT, counter=0 and synchronizer=0.
REQ-031 SHALL, if reset asserts mid-frame, discard the partial byte and issue no write.

Configuration
REQ-032 SHALL, with CASREC_PARITY_CHECK_EN defined, compare the parity bit against the expected value (1 when the data has an even number of ones); on mismatch it sets parity_err and still writes the byte.
REQ-033 SHALL, with CASREC_PARITY_CHECK_EN undefined, consume the parity bit unchecked and tie parity_err to 0.

Verification
REQ-034 SHALL verify: en=1; leader of 20 one-bits (20800-cycle periods), start bit (41667), 0x5A, parity 1, stop 1 -> single bram_wr with addr 0, data 0x5A; tape_len=1.
REQ-035 SHALL verify: two frames 0x01, 0xFF -> writes at addr 0 and 1; tape_len=2; error flags stay 0.
REQ-036 SHALL verify: frame 0x5A with parity 0 (macro defined) -> write of 0x5A and parity_err=1; macro undefined -> parity_err=0.
REQ-037 SHALL verify: frame whose stop bit is 0 -> no write and frame_err=1; a 150000-cycle gap after 4 data bits -> no write, no error flag, active=0.
REQ-038 SHALL verify: ADDR_W=2, 5 frames -> 4 writes at addrs 0..3, full=1, fifth frame not written; rewind -> tape_len=0, full=0.
REQ-039 SHALL verify: 3000-cycle glitch pulses inside a frame are ignored (byte decodes correctly); en=0 mid-frame -> no write and pointer retained.
